// File: rtl/data_memory.sv
// 256x16 data memory with memory-mapped LED, seven-segment, button and switch I/O.
// Optional macro DATA_MEM_SEG_EN adds the seven-segment register at 0x45 and the scan logic.
module data_memory #(
    parameter int SCAN_BITS       = 16,
    parameter int DEBUG_SCAN_BITS = 2
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [7:0]  address,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [15:0] input_data,
    output logic [15:0] output_data,
    input  logic [15:0] SW,
    input  logic [4:0]  BTNS,
    output logic [15:0] LED,
    output logic [7:0]  CA,
    output logic [7:0]  AN,
    input  logic        debug_mode
);

    localparam logic [7:0] ADDR_LED = 8'h44;
    localparam logic [7:0] ADDR_SEG = 8'h45;
    localparam logic [7:0] ADDR_BTN = 8'h4C;
    localparam logic [7:0] ADDR_SW  = 8'h4E;

    logic [15:0] mem [0:255];
    logic [15:0] led_reg;
    logic [15:0] sw_meta, sw_sync;
    logic [4:0]  btn_meta, btn_sync;
    logic [15:0] rd_word;
    logic        ram_wr;

`ifdef DATA_MEM_SEG_EN
    logic [15:0] seg_reg;
    logic        is_seg;
    assign is_seg = (address == ADDR_SEG);
`else
    logic        is_seg;
    logic        unused_debug_mode;
    assign is_seg            = 1'b0;
    assign unused_debug_mode = debug_mode;
`endif

    // I/O registers shadow their RAM words; read-only ports drop writes entirely.
    assign ram_wr = write_en && (address != ADDR_LED) && !is_seg &&
                    (address != ADDR_BTN) && (address != ADDR_SW);

    always_ff @(posedge CLK) begin
        if (ram_wr)
            mem[address] <= input_data;
    end

    always_comb begin
        rd_word = mem[address];
        case (address)
            ADDR_LED: rd_word = led_reg;
`ifdef DATA_MEM_SEG_EN
            ADDR_SEG: rd_word = seg_reg;
`endif
            ADDR_BTN: rd_word = {11'b0, btn_sync};
            ADDR_SW:  rd_word = sw_sync;
            default:  ;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            output_data <= 16'h0000;
            led_reg     <= 16'h0000;
            sw_meta     <= 16'h0000;
            sw_sync     <= 16'h0000;
            btn_meta    <= 5'b0;
            btn_sync    <= 5'b0;
        end else begin
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
            btn_meta <= BTNS;
            btn_sync <= btn_meta;
            if (read_en)
                output_data <= rd_word;
            if (write_en && address == ADDR_LED)
                led_reg <= input_data;
        end
    end

    assign LED = led_reg;

`ifdef DATA_MEM_SEG_EN
    logic [SCAN_BITS-1:0] scan_cnt;
    logic [2:0]           digit;
    logic                 scan_wrap;
    logic [3:0]           nib;

    function automatic logic [7:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_seg = 8'hC0;
            4'h1: hex_seg = 8'hF9;
            4'h2: hex_seg = 8'hA4;
            4'h3: hex_seg = 8'hB0;
            4'h4: hex_seg = 8'h99;
            4'h5: hex_seg = 8'h92;
            4'h6: hex_seg = 8'h82;
            4'h7: hex_seg = 8'hF8;
            4'h8: hex_seg = 8'h80;
            4'h9: hex_seg = 8'h90;
            4'hA: hex_seg = 8'h88;
            4'hB: hex_seg = 8'h83;
            4'hC: hex_seg = 8'hC6;
            4'hD: hex_seg = 8'hA1;
            4'hE: hex_seg = 8'h86;
            default: hex_seg = 8'h8E;
        endcase
    endfunction

    // Counter restarts from zero on every wrap, so a mode switch lands on the next wrap.
    assign scan_wrap = debug_mode ? (&scan_cnt[DEBUG_SCAN_BITS-1:0]) : (&scan_cnt);

    always_comb begin
        case (digit[1:0])
            2'd0:    nib = seg_reg[3:0];
            2'd1:    nib = seg_reg[7:4];
            2'd2:    nib = seg_reg[11:8];
            default: nib = seg_reg[15:12];
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg  <= 16'h0000;
            scan_cnt <= '0;
            digit    <= 3'd0;
            AN       <= 8'hFF;
            CA       <= 8'hFF;
        end else begin
            if (write_en && is_seg)
                seg_reg <= input_data;
            if (scan_wrap) begin
                scan_cnt <= '0;
                digit    <= digit + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_BITS'(1);
            end
            AN <= digit[2] ? 8'hFF : ~(8'h01 << digit);
            CA <= digit[2] ? 8'hFF : hex_seg(nib);
        end
    end
`else
    assign CA = 8'hFF;
    assign AN = 8'hFF;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; inputs driven on falling edge, outputs sampled there.
module tb_data_memory;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic [7:0]  address;
    logic        read_en, write_en;
    logic [15:0] input_data;
    logic [15:0] output_data;
    logic [15:0] SW;
    logic [4:0]  BTNS;
    logic [15:0] LED;
    logic [7:0]  CA, AN;
    logic        debug_mode;

    int checks = 0;
    int errors = 0;

    data_memory dut (
        .CLK(CLK), .rst_n(rst_n), .address(address), .read_en(read_en),
        .write_en(write_en), .input_data(input_data), .output_data(output_data),
        .SW(SW), .BTNS(BTNS), .LED(LED), .CA(CA), .AN(AN), .debug_mode(debug_mode)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        @(negedge CLK);
        address = a; input_data = d; write_en = 1'b1; read_en = 1'b0;
        @(negedge CLK);
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        @(negedge CLK);
        address = a; read_en = 1'b1; write_en = 1'b0;
        @(negedge CLK);
        read_en = 1'b0;
    endtask

    initial begin
        logic [4:0] seen;
        rst_n = 1'b0; address = 8'h00; read_en = 1'b0; write_en = 1'b0;
        input_data = 16'h0000; SW = 16'h0000; BTNS = 5'b0; debug_mode = 1'b1;
        #12;
        chk("rst_output_data", output_data, 16'h0000);
        chk("rst_led", LED, 16'h0000);
        chk("rst_an", {8'h00, AN}, 16'h00FF);
        chk("rst_ca", {8'h00, CA}, 16'h00FF);
        @(negedge CLK);
        rst_n = 1'b1;

        // RAM round trip and hold
        wr(8'h74, 16'hABCD);
        rd(8'h74);
        chk("ram_rd_74", output_data, 16'hABCD);
        address = 8'h10;
        repeat (2) @(negedge CLK);
        chk("ram_hold", output_data, 16'hABCD);

        // Read-before-write on the same address
        wr(8'h10, 16'h2222);
        @(negedge CLK);
        address = 8'h10; input_data = 16'h3333; write_en = 1'b1; read_en = 1'b1;
        @(negedge CLK);
        write_en = 1'b0; read_en = 1'b0;
        chk("rbw_old", output_data, 16'h2222);
        rd(8'h10);
        chk("rbw_new", output_data, 16'h3333);

        // Unused I/O slot is plain RAM
        wr(8'h40, 16'h0F0F);
        rd(8'h40);
        chk("ram_rd_40", output_data, 16'h0F0F);

        // LED register
        wr(8'h44, 16'h1234);
        chk("led_after_wr", LED, 16'h1234);
        rd(8'h44);
        chk("led_rd", output_data, 16'h1234);

        // Switches: write ignored, then 2-cycle sync latency
        wr(8'h4E, 16'h9876);
        rd(8'h4E);
        chk("sw_ro", output_data, 16'h0000);
        @(negedge CLK);
        SW = 16'h9876; address = 8'h4E; read_en = 1'b1;
        @(negedge CLK);
        chk("sw_lat1", output_data, 16'h0000);
        @(negedge CLK);
        chk("sw_lat2", output_data, 16'h0000);
        @(negedge CLK);
        read_en = 1'b0;
        chk("sw_sync", output_data, 16'h9876);

        // Buttons, zero-extended; writes dropped
        BTNS = 5'b10101;
        repeat (2) @(negedge CLK);
        rd(8'h4C);
        chk("btn_rd", output_data, 16'h0015);
        wr(8'h4C, 16'hFFFF);
        rd(8'h4C);
        chk("btn_ro", output_data, 16'h0015);

`ifdef DATA_MEM_SEG_EN
        wr(8'h45, 16'h0A3F);
        rd(8'h45);
        chk("seg_rd", output_data, 16'h0A3F);
        seen = 5'b0;
        for (int i = 0; i < 48; i++) begin
            @(negedge CLK);
            case (AN)
                8'hFE: begin chk("seg_d0_ca", {8'h00, CA}, 16'h008E); seen[0] = 1'b1; end
                8'hFD: begin chk("seg_d1_ca", {8'h00, CA}, 16'h00B0); seen[1] = 1'b1; end
                8'hFB: begin chk("seg_d2_ca", {8'h00, CA}, 16'h0088); seen[2] = 1'b1; end
                8'hF7: begin chk("seg_d3_ca", {8'h00, CA}, 16'h00C0); seen[3] = 1'b1; end
                8'hFF: seen[4] = 1'b1;
                default: chk("seg_an_valid", {8'h00, AN}, 16'h00FF);
            endcase
        end
        chk("seg_all_digits", {11'b0, seen}, 16'h001F);
`else
        wr(8'h45, 16'h5555);
        rd(8'h45);
        chk("ram_rd_45", output_data, 16'h5555);
        chk("seg_off_an", {8'h00, AN}, 16'h00FF);
        chk("seg_off_ca", {8'h00, CA}, 16'h00FF);
`endif

        // Asynchronous reset mid-cycle
        rd(8'h44);
        chk("pre_rst_rd", output_data, 16'h1234);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_led", LED, 16'h0000);
        chk("arst_output_data", output_data, 16'h0000);
        chk("arst_an", {8'h00, AN}, 16'h00FF);
        @(negedge CLK);
        rst_n = 1'b1;
        rd(8'h74);
        chk("ram_after_rst", output_data, 16'hABCD);
        chk("led_after_rst", LED, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
